// File: rtl/sub_alu.sv
// sub_alu: registered signed subtractor producing Result and {N,Z,C,V} flags,
// with selectable flag update and a one-cycle valid strobe per capture.
module sub_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Flag,
  input  logic             S,
  input  logic             en,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       New_Flag,
  output logic             valid
);
  logic [WIDTH:0]   w_d;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flag;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flag;
  logic             r_valid;
  // Carry-out of the widened add is the inverted borrow.
  assign w_d    = {1'b0, In1} + {1'b0, ~In2} + (WIDTH+1)'(1);
  assign w_res  = w_d[WIDTH-1:0];
  assign w_flag = S ? {w_res[WIDTH-1], w_res == '0, w_d[WIDTH],
                       (In1[WIDTH-1] != In2[WIDTH-1]) && (w_res[WIDTH-1] != In1[WIDTH-1])}
                    : Flag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_flag   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_result <= w_res;
        r_flag   <= w_flag;
      end
    end
  end
  assign Result   = r_result;
  assign New_Flag = r_flag;
  assign valid    = r_valid;
endmodule

// File: tb/tb_sub_alu.sv
// tb_sub_alu: directed and random checks of sub_alu against a scoreboard of
// expected results, built from reference constants and an integer model.
module tb_sub_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] In1 = '0, In2 = '0;
  logic [3:0]  Flag = '0;
  logic        S = 1'b1, en = 1'b0;
  logic [31:0] Result;
  logic [3:0]  New_Flag;
  logic        valid;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] r; logic [3:0] f;} exp_t;
  exp_t q[$];
  exp_t last;

  sub_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .In1(In1), .In2(In2), .Flag(Flag), .S(S), .en(en),
    .Result(Result), .New_Flag(New_Flag), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] fl, input logic s);
    exp_t e;
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    e.r = d[31:0];
    e.f = s ? {e.r[31], e.r == 32'd0, a >= b, d > 64'sd2147483647 || d < -64'sd2147483648} : fl;
    return e;
  endfunction

  // Drives one capture, pushes its expectation, then checks after the edge.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] fl, input logic s, input logic [31:0] er, input logic [3:0] ef);
    exp_t e;
    In1 = a; In2 = b; Flag = fl; S = s; en = 1'b1;
    q.push_back('{er, ef});
    @(posedge clk); #1;
    e = q.pop_front();
    last = e;
    chk({tag, "_res"}, Result, e.r);
    chk({tag, "_flag"}, {28'd0, New_Flag}, {28'd0, e.f});
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    exp_t m;
    logic [31:0] a, b;
    logic [3:0] fl;
    logic s;
    #2;
    chk("reset_res", Result, 32'd0);
    chk("reset_flag", {28'd0, New_Flag}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    op("p2m3", 32'd2, 32'd3, 4'b0000, 1'b1, 32'hFFFFFFFF, 4'b1000);
    op("p1mn3", 32'd1, -32'sd3, 4'b0000, 1'b1, 32'd4, 4'b0000);
    op("n6m8", -32'sd6, 32'd8, 4'b0000, 1'b1, -32'sd14, 4'b1010);
    op("p4mn4", 32'd4, -32'sd4, 4'b0000, 1'b1, 32'd8, 4'b0000);
    op("eq_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'd0, 4'b0110);
    op("eq_ten", 32'd10, 32'd10, 4'b0000, 1'b1, 32'd0, 4'b0110);
    op("min_m1", 32'h80000000, 32'd1, 4'b0000, 1'b1, 32'h7FFFFFFF, 4'b0011);
    op("max_mn1", 32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h80000000, 4'b1001);
    op("pass", 32'd5, 32'd7, 4'b0101, 1'b0, -32'sd2, 4'b0101);
    en = 1'b0; In1 = 32'd99; In2 = 32'd1; S = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("hold_res", Result, last.r);
      chk("hold_flag", {28'd0, New_Flag}, {28'd0, last.f});
      chk("hold_valid", {31'd0, valid}, 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = (i == 3) ? a : $urandom; fl = 4'($urandom); s = 1'($urandom);
      m = model(a, b, fl, s);
      op("rand", a, b, fl, s, m.r, m.f);
    end
    en = 1'b1; In1 = 32'd40; In2 = 32'd2;
    #2 rst = 1'b1; #1;
    chk("arst_res", Result, 32'd0);
    chk("arst_flag", {28'd0, New_Flag}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("discard_res", Result, 32'd0);
    chk("discard_valid", {31'd0, valid}, 32'd0);
    op("recover", 32'd40, 32'd2, 4'b0000, 1'b1, 32'd38, 4'b0010);
    en = 1'b0;
    @(posedge clk); #1;
    chk("end_valid", {31'd0, valid}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub_alu.md
SUB_ALU -- requirements
Module: sub_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; all requirements below are written for the default.
REQ-002 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: In1  input  WIDTH  signed minuend.
REQ-005 Port: In2  input  WIDTH  signed subtrahend.
REQ-006 Port: Flag  input  4  current flags, bit order [3:0] = {N, Z, C, V}.
REQ-007 Port: S  input  1  set-flags: 1 = flags come from this subtraction, 0 = Flag is passed through unchanged.
REQ-008 Port: en  input  1  capture strobe: operands, Flag and S are sampled on a clk edge only when en=1.
REQ-009 Port: Result  output  WIDTH  signed difference, registered.
REQ-010 Port: New_Flag  output  4  resulting flags {N, Z, C, V}, registered.
REQ-011 Port: valid  output  1  high for exactly one cycle after each en=1 capture.

Function
REQ-012 Arithmetic: D = In1 + ~In2 + 1, computed in WIDTH+1 bits; Result = D[WIDTH-1:0] (two's-complement wrap, no saturation).
REQ-013 N = Result[WIDTH-1].
REQ-014 Z = 1 iff Result == 0.
REQ-015 C = carry-out D[WIDTH], i.e. NOT borrow; C=1 iff unsigned In1 >= unsigned In2.
REQ-016 V = (In1[MSB] != In2[MSB]) AND (Result[MSB] != In1[MSB]).
REQ-017 S=1: New_Flag = {N, Z, C, V} from REQ-013..016.
REQ-018 S=0: New_Flag = Flag exactly as sampled; Result is still updated.
REQ-019 Latency: exactly one cycle. Inputs sampled at edge k with en=1 appear on Result/New_Flag after edge k, with valid=1 during the following cycle.
REQ-020 en=0 at an edge: Result and New_Flag hold their values and valid=0.
REQ-021 Back-to-back en=1 gives one result per cycle, with valid held high continuously.
REQ-022 The flag logic is purely a function of the sampled operands; there is no sticky or accumulated state.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk: Result=0, New_Flag=4'b0000, valid=0.
REQ-025 Reset asserted mid-operation discards the pending capture; the first result after reset release comes from the first en=1 edge with rst=0.

Verification (S=1, en=1, Flag=0000 unless stated; each check is made one cycle after capture)
REQ-026 In1=2, In2=3 -> Result=-1, New_Flag=1000; In1=1, In2=-3 -> Result=4, New_Flag=0000.
REQ-027 In1=-6, In2=8 -> Result=-14, New_Flag=1010; In1=4, In2=-4 -> Result=8, New_Flag=0000.
REQ-028 In1=In2=32'hFFFFFFFF -> Result=0, New_Flag=0110; In1=In2=10 -> Result=0, New_Flag=0110.
REQ-029 In1=32'h80000000, In2=1 -> Result=32'h7FFFFFFF, New_Flag=0011; In1=32'h7FFFFFFF, In2=-1 -> Result=32'h80000000, New_Flag=1001.
REQ-030 S=0, Flag=0101, In1=5, In2=7 -> Result=-2, New_Flag=0101.
REQ-031 en=0 hold check: outputs stay unchanged and valid=0. Reset check: rst pulsed between clk edges -> outputs go to 0 immediately, and recover on the next en=1 capture.
